// File: rtl/cordic_octant_ctrl.sv
// Octant fold / unfold controller around cordic_core for the Sobel edge path.
// Admits whole frames only, tracks the octant tag alongside the core, and rebuilds full-circle angle.
module cordic_octant_ctrl #(
  parameter int DW       = 16,
  parameter int DW_DOT   = 4,
  parameter int DW_NOR   = 20,
  parameter int T_IR_NUM = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   din_vsync,
  input  logic                   din_hsync,
  input  logic signed [DW-1:0]   din_gx,
  input  logic signed [DW-1:0]   din_gy,
  output logic                   core_din_vsync,
  output logic                   core_din_hsync,
  output logic [DW-1:0]          core_din_x,
  output logic [DW-1:0]          core_din_y,
  output logic [DW_NOR-1:0]      core_din_z,
  input  logic                   core_dout_vsync,
  input  logic                   core_dout_hsync,
  input  logic [DW+DW_DOT-1:0]   core_dout_x,
  input  logic [DW_NOR-1:0]      core_dout_z,
  output logic                   dout_vsync,
  output logic                   dout_hsync,
  output logic [DW+DW_DOT-1:0]   dout_mag,
  output logic [DW_NOR-1:0]      dout_ang,
  output logic                   frame_done,
  output logic [31:0]            frame_pix,
  output logic                   sync_err,
  output logic [2:0]             dbg_state
);

  localparam int CORE_LAT  = T_IR_NUM;
  localparam int FLUSH_LEN = CORE_LAT + 2;
  localparam int CW        = $clog2(FLUSH_LEN + 1);
  localparam logic [DW-1:0]     SAT_MAX = DW'((1 << (DW - 2)) - 1);
  localparam logic [DW_NOR-1:0] QUARTER = DW_NOR'(1 << (DW_NOR - 2));
  localparam logic [DW_NOR-1:0] HALF    = DW_NOR'(1 << (DW_NOR - 1));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q;
  logic            vs_prev_q;
  logic [CW-1:0]   flush_cnt_q;
  logic [31:0]     pix_cnt_q;
  logic [31:0]     frame_pix_q;
  logic            frame_done_q;
  logic            core_vs_q;
  logic            core_hs_q;
  logic [DW-1:0]   core_x_q;
  logic [DW-1:0]   core_y_q;
  logic [2:0]      tag_q;
  logic [4:0]      line_q [CORE_LAT];
  logic            dout_vs_q;
  logic            dout_hs_q;
  logic [DW+DW_DOT-1:0] dout_mag_q;
  logic [DW_NOR-1:0]    dout_ang_q;
  logic            sync_err_q;

  function automatic logic [DW-1:0] sat_abs(input logic signed [DW-1:0] v);
    logic [DW-1:0] mag;
    mag = v[DW-1] ? $unsigned(-v) : $unsigned(v);
    return (mag > SAT_MAX) ? SAT_MAX : mag;
  endfunction

  logic vs_rise;
  logic admit;
  assign vs_rise = din_vsync & ~vs_prev_q;
  // The rising-edge cycle itself is admitted so the core sees the full vsync pulse.
  assign admit = ((state_q == S_ARM) && vs_rise) || ((state_q == S_RUN) && din_vsync);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vs_prev_q    <= 1'b0;
      flush_cnt_q  <= '0;
      pix_cnt_q    <= '0;
      frame_pix_q  <= '0;
      frame_done_q <= 1'b0;
      core_vs_q    <= 1'b0;
      core_hs_q    <= 1'b0;
    end else begin
      vs_prev_q    <= din_vsync;
      frame_done_q <= 1'b0;
      core_vs_q    <= admit;
      core_hs_q    <= admit & din_hsync;
      if (core_hs_q && (pix_cnt_q != '1)) pix_cnt_q <= pix_cnt_q + 32'd1;
      case (state_q)
        S_IDLE: if (en) state_q <= S_ARM;
        S_ARM: begin
          if (vs_rise) begin
            state_q   <= S_RUN;
            pix_cnt_q <= '0;
          end
        end
        S_RUN: begin
          if (!din_vsync) begin
            state_q     <= S_FLUSH;
            flush_cnt_q <= CW'(1);
          end
        end
        S_FLUSH: begin
          // Hold until the last admitted pixel has left the output register.
          if (flush_cnt_q == CW'(FLUSH_LEN - 1)) begin
            state_q      <= S_DONE;
            frame_done_q <= 1'b1;
            frame_pix_q  <= pix_cnt_q;
          end else begin
            flush_cnt_q <= flush_cnt_q + CW'(1);
          end
        end
        S_DONE: state_q <= en ? S_ARM : S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [DW-1:0] ax;
  logic [DW-1:0] ay;
  logic          swap;

  always_comb begin
    ax   = sat_abs(din_gx);
    ay   = sat_abs(din_gy);
    swap = (ay > ax);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_x_q <= '0;
      core_y_q <= '0;
      tag_q    <= '0;
    end else begin
      core_x_q <= swap ? ay : ax;
      core_y_q <= swap ? ax : ay;
      tag_q    <= {din_gx[DW-1], din_gy[DW-1], swap};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CORE_LAT; i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= {tag_q, core_vs_q, core_hs_q};
      for (int i = 1; i < CORE_LAT; i++) line_q[i] <= line_q[i-1];
    end
  end

  logic                l_sx;
  logic                l_sy;
  logic                l_swap;
  logic                l_vs;
  logic                l_hs;
  logic [DW_NOR-1:0]   oct_ang;
  logic [DW_NOR-1:0]   full_ang;

  assign {l_sx, l_sy, l_swap, l_vs, l_hs} = line_q[CORE_LAT-1];

  // Unfold: undo the x/y swap, then mirror into the quadrant given by the signs.
  always_comb begin
    oct_ang = l_swap ? (QUARTER - core_dout_z) : core_dout_z;
    case ({l_sx, l_sy})
      2'b00:   full_ang = oct_ang;
      2'b10:   full_ang = HALF - oct_ang;
      2'b11:   full_ang = HALF + oct_ang;
      default: full_ang = '0 - oct_ang;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_vs_q  <= 1'b0;
      dout_hs_q  <= 1'b0;
      dout_mag_q <= '0;
      dout_ang_q <= '0;
      sync_err_q <= 1'b0;
    end else begin
      dout_vs_q  <= core_dout_vsync;
      dout_hs_q  <= core_dout_hsync;
      dout_mag_q <= core_dout_hsync ? core_dout_x : '0;
      dout_ang_q <= core_dout_hsync ? full_ang : '0;
      if ((core_dout_hsync != l_hs) || (core_dout_vsync != l_vs)) sync_err_q <= 1'b1;
    end
  end

  assign core_din_vsync = core_vs_q;
  assign core_din_hsync = core_hs_q;
  assign core_din_x     = core_x_q;
  assign core_din_y     = core_y_q;
  assign core_din_z     = '0;
  assign dout_vsync     = dout_vs_q;
  assign dout_hsync     = dout_hs_q;
  assign dout_mag       = dout_mag_q;
  assign dout_ang       = dout_ang_q;
  assign frame_done     = frame_done_q;
  assign frame_pix      = frame_pix_q;
  assign sync_err       = sync_err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_cordic_octant_ctrl.sv
// Bench for cordic_octant_ctrl: an ideal cordic_core stand-in plus a floating-point atan2/hypot reference.
`timescale 1ns/1ps
module tb_cordic_octant_ctrl;

  localparam int  DW        = 16;
  localparam int  DW_DOT    = 4;
  localparam int  DW_NOR    = 20;
  localparam int  T_IR_NUM  = 15;
  localparam int  LAT       = T_IR_NUM;
  localparam int  TOTAL_LAT = T_IR_NUM + 2;
  localparam real PI        = 3.14159265358979323846;
  localparam real ANG_SCALE = 1048576.0;
  localparam real GAIN      = 1.6468;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic din_vsync = 1'b0;
  logic din_hsync = 1'b0;
  logic [DW-1:0] din_gx = '0;
  logic [DW-1:0] din_gy = '0;
  logic core_din_vsync, core_din_hsync;
  logic [DW-1:0] core_din_x, core_din_y;
  logic [DW_NOR-1:0] core_din_z;
  logic core_dout_vsync, core_dout_hsync;
  logic [DW+DW_DOT-1:0] core_dout_x;
  logic [DW_NOR-1:0] core_dout_z;
  logic dout_vsync, dout_hsync;
  logic [DW+DW_DOT-1:0] dout_mag;
  logic [DW_NOR-1:0] dout_ang;
  logic frame_done;
  logic [31:0] frame_pix;
  logic sync_err;
  logic [2:0] dbg_state;

  cordic_octant_ctrl #(.DW(DW), .DW_DOT(DW_DOT), .DW_NOR(DW_NOR), .T_IR_NUM(T_IR_NUM)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .din_vsync(din_vsync), .din_hsync(din_hsync), .din_gx(din_gx), .din_gy(din_gy),
    .core_din_vsync(core_din_vsync), .core_din_hsync(core_din_hsync),
    .core_din_x(core_din_x), .core_din_y(core_din_y), .core_din_z(core_din_z),
    .core_dout_vsync(core_dout_vsync), .core_dout_hsync(core_dout_hsync),
    .core_dout_x(core_dout_x), .core_dout_z(core_dout_z),
    .dout_vsync(dout_vsync), .dout_hsync(dout_hsync), .dout_mag(dout_mag), .dout_ang(dout_ang),
    .frame_done(frame_done), .frame_pix(frame_pix), .sync_err(sync_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters and check task ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
    longint d;
    n_checks++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic int sat_abs_tb(input int v);
    int a;
    a = (v < 0) ? -v : v;
    return (a > 16383) ? 16383 : a;
  endfunction

  function automatic int sat_signed(input int v);
    return (v < 0) ? -sat_abs_tb(v) : sat_abs_tb(v);
  endfunction

  function automatic logic [19:0] ref_mag(input int gx, input int gy);
    real sx, sy;
    sx = real'(sat_signed(gx));
    sy = real'(sat_signed(gy));
    return 20'($rtoi($sqrt(sx * sx + sy * sy) * GAIN * 16.0 + 0.5));
  endfunction

  function automatic logic [19:0] ref_ang(input int gx, input int gy);
    real a;
    int v;
    a = $atan2(real'(sat_signed(gy)), real'(sat_signed(gx)));
    if (a < 0.0) a = a + 2.0 * PI;
    v = $rtoi(a * ANG_SCALE / (2.0 * PI) + 0.5);
    if (v >= 1048576) v = v - 1048576;
    return 20'(v);
  endfunction

  function automatic longint near_ang(input longint obs, input longint exp);
    if (exp - obs > 524288) return exp - 1048576;
    if (obs - exp > 524288) return exp + 1048576;
    return exp;
  endfunction

  // ---------------- ideal cordic_core stand-in ----------------
  function automatic logic [19:0] cm_mag(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return 20'($rtoi($sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * GAIN * 16.0 + 0.5));
  endfunction

  function automatic logic [19:0] cm_ang(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return 20'($rtoi($atan2(real'(y), real'(x)) * ANG_SCALE / (2.0 * PI) + 0.5));
  endfunction

  logic [19:0] cm_x_q [LAT];
  logic [19:0] cm_z_q [LAT];
  logic [LAT-1:0] cm_vs_q;
  logic [LAT-1:0] cm_hs_q;
  logic hs_flip = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        cm_x_q[i] <= '0;
        cm_z_q[i] <= '0;
      end
      cm_vs_q <= '0;
      cm_hs_q <= '0;
    end else begin
      cm_vs_q   <= {cm_vs_q[LAT-2:0], core_din_vsync};
      cm_hs_q   <= {cm_hs_q[LAT-2:0], core_din_hsync};
      cm_x_q[0] <= cm_mag(core_din_x, core_din_y);
      cm_z_q[0] <= cm_ang(core_din_x, core_din_y);
      for (int i = 1; i < LAT; i++) begin
        cm_x_q[i] <= cm_x_q[i-1];
        cm_z_q[i] <= cm_z_q[i-1];
      end
    end
  end

  assign core_dout_x     = cm_x_q[LAT-1];
  assign core_dout_z     = cm_z_q[LAT-1];
  assign core_dout_vsync = cm_vs_q[LAT-1];
  assign core_dout_hsync = cm_hs_q[LAT-1] ^ hs_flip;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_cx_q[$];
  logic [DW-1:0] exp_cy_q[$];
  int            exp_ccyc_q[$];
  logic [19:0]   exp_mag_q[$];
  logic [19:0]   exp_ang_q[$];
  int            exp_dcyc_q[$];
  int            exp_done_q[$];
  logic [31:0]   exp_pix_q[$];
  int            dir_gx[$];
  int            dir_gy[$];
  int core_vs_cnt = 0;
  int done_cnt = 0;
  logic ignore_dout = 1'b0;

  logic [DW-1:0] m_cx, m_cy;
  logic [19:0] m_mag, m_ang;
  logic [31:0] m_pix;
  int m_cyc;

  always @(negedge clk) begin
    if (rst_n) begin
      if (core_din_vsync) core_vs_cnt++;
      if (core_din_hsync) begin
        if (exp_cx_q.size() == 0) chk("core_hs_unexpected", 1, 0, 0);
        else begin
          m_cx = exp_cx_q.pop_front();
          m_cy = exp_cy_q.pop_front();
          m_cyc = exp_ccyc_q.pop_front();
          chk("core_x", core_din_x, m_cx, 0);
          chk("core_y", core_din_y, m_cy, 0);
          chk("core_lat", cyc, m_cyc, 0);
          chk("core_z", core_din_z, 0, 0);
        end
      end
      if (dout_hsync && !ignore_dout) begin
        if (exp_mag_q.size() == 0) chk("dout_unexpected", 1, 0, 0);
        else begin
          m_mag = exp_mag_q.pop_front();
          m_ang = exp_ang_q.pop_front();
          m_cyc = exp_dcyc_q.pop_front();
          chk("dout_mag", dout_mag, m_mag, 2);
          chk("dout_ang", dout_ang, near_ang(dout_ang, m_ang), 4);
          chk("dout_lat", cyc, m_cyc, 0);
        end
      end else if (!dout_hsync) begin
        chk("dout_idle_zero", {dout_mag, dout_ang}, 0, 0);
      end
      if (frame_done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) chk("done_unexpected", 1, 0, 0);
        else begin
          m_cyc = exp_done_q.pop_front();
          m_pix = exp_pix_q.pop_front();
          chk("done_lat", cyc, m_cyc, 0);
          chk("frame_pix", frame_pix, m_pix, 0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pick_random(output int gx, output int gy);
    case ($urandom_range(0, 3))
      0: begin
        gx = int'($urandom_range(0, 65535)) - 32768;
        gy = int'($urandom_range(0, 65535)) - 32768;
      end
      1: begin
        gx = int'($urandom_range(0, 16)) - 8;
        gy = int'($urandom_range(0, 16)) - 8;
      end
      2: begin
        gx = int'($urandom_range(0, 65535)) - 32768;
        gy = ($urandom_range(0, 1) == 1) ? gx : -gx;
        if (gy > 32767) gy = 32767;
      end
      default: begin
        gx = int'($urandom_range(0, 4000)) - 2000;
        gy = int'($urandom_range(0, 65535)) - 32768;
      end
    endcase
  endtask

  task automatic put_pixel(input bit admit);
    int gx, gy, ax, ay;
    if (dir_gx.size() != 0) begin
      gx = dir_gx.pop_front();
      gy = dir_gy.pop_front();
    end else begin
      pick_random(gx, gy);
    end
    din_vsync = 1'b1;
    din_hsync = 1'b1;
    din_gx = 16'(gx);
    din_gy = 16'(gy);
    if (admit) begin
      ax = sat_abs_tb(gx);
      ay = sat_abs_tb(gy);
      exp_cx_q.push_back(16'((ax > ay) ? ax : ay));
      exp_cy_q.push_back(16'((ax > ay) ? ay : ax));
      exp_ccyc_q.push_back(cyc + 1);
      exp_mag_q.push_back(ref_mag(gx, gy));
      exp_ang_q.push_back(ref_ang(gx, gy));
      exp_dcyc_q.push_back(cyc + TOTAL_LAT);
    end
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_vsync = 1'b0;
      din_hsync = 1'b0;
      din_gx = '0;
      din_gy = '0;
    end
  endtask

  task automatic drive_frame(input int lines, input int ppl, input bit admit,
                             input int en_at, input logic en_val);
    int k;
    k = 0;
    @(negedge clk);
    din_vsync = 1'b1;
    din_hsync = 1'b0;
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ppl; p++) begin
        @(negedge clk);
        put_pixel(admit);
        if (k == en_at) en = en_val;
        k++;
      end
      repeat (2) begin
        @(negedge clk);
        din_hsync = 1'b0;
        din_gx = '0;
        din_gy = '0;
      end
    end
    @(negedge clk);
    din_vsync = 1'b0;
    din_hsync = 1'b0;
    if (admit) begin
      exp_done_q.push_back(cyc + TOTAL_LAT);
      exp_pix_q.push_back(32'(lines * ppl));
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    chk({pfx, "_core_vs"}, core_din_vsync, 0, 0);
    chk({pfx, "_core_hs"}, core_din_hsync, 0, 0);
    chk({pfx, "_core_x"}, core_din_x, 0, 0);
    chk({pfx, "_core_y"}, core_din_y, 0, 0);
    chk({pfx, "_core_z"}, core_din_z, 0, 0);
    chk({pfx, "_dout_vs"}, dout_vsync, 0, 0);
    chk({pfx, "_dout_hs"}, dout_hsync, 0, 0);
    chk({pfx, "_mag"}, dout_mag, 0, 0);
    chk({pfx, "_ang"}, dout_ang, 0, 0);
    chk({pfx, "_done"}, frame_done, 0, 0);
    chk({pfx, "_pix"}, frame_pix, 0, 0);
    chk({pfx, "_sync_err"}, sync_err, 0, 0);
    chk({pfx, "_state"}, dbg_state, 0, 0);
  endtask

  // ---------------- main sequence ----------------
  int vs0, d0;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    en = 1'b1;
    drive_idle(5);

    // Directed octant/quadrant corners, then random fill.
    dir_gx = '{3, -3, 5, 0, -32768, 0, -32768, 32767, 0, -5, 7, -7};
    dir_gy = '{4, -4, 0, -5, 0, 0, 32767, -32768, 5, 0, -7, 7};
    drive_frame(2, 8, 1, -1, 1'b1);
    drive_idle(25);
    for (int f = 0; f < 6; f++) begin
      drive_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 12)), 1, -1, 1'b1);
      drive_idle(25);
    end

    // en drops mid-frame: frame still completes, FSM parks in IDLE.
    d0 = done_cnt;
    drive_frame(2, 6, 1, 3, 1'b0);
    drive_idle(25);
    chk("en_off_done", done_cnt - d0, 1, 0);
    chk("fsm_idle", dbg_state, 0, 0);
    vs0 = core_vs_cnt;
    d0 = done_cnt;
    drive_frame(2, 6, 0, -1, 1'b0);
    drive_idle(25);
    chk("idle_no_admit_vs", core_vs_cnt - vs0, 0, 0);
    chk("idle_no_done", done_cnt - d0, 0, 0);

    // en rises while vsync is already high: that frame is dropped.
    vs0 = core_vs_cnt;
    drive_frame(4, 8, 0, 2, 1'b1);
    drive_idle(25);
    chk("dropped_core_vs", core_vs_cnt - vs0, 0, 0);
    d0 = done_cnt;
    drive_frame(4, 8, 1, -1, 1'b1);
    drive_idle(25);
    chk("done_pulses", done_cnt - d0, 1, 0);

    // Tag-line desync detection.
    chk("sync_err_clean", sync_err, 0, 0);
    ignore_dout = 1'b1;
    @(negedge clk);
    hs_flip = 1'b1;
    @(negedge clk);
    hs_flip = 1'b0;
    drive_idle(3);
    chk("sync_err_set", sync_err, 1, 0);
    drive_idle(10);
    chk("sync_err_sticky", sync_err, 1, 0);
    ignore_dout = 1'b0;

    // Reset in the middle of an admitted frame.
    @(negedge clk);
    din_vsync = 1'b1;
    din_hsync = 1'b0;
    for (int p = 0; p < 5; p++) begin
      @(negedge clk);
      put_pixel(1);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_cx_q.delete(); exp_cy_q.delete(); exp_ccyc_q.delete();
    exp_mag_q.delete(); exp_ang_q.delete(); exp_dcyc_q.delete();
    exp_done_q.delete(); exp_pix_q.delete();
    @(negedge clk);
    check_outputs_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    vs0 = core_vs_cnt;
    for (int p = 0; p < 6; p++) begin
      @(negedge clk);
      put_pixel(0);
    end
    drive_idle(25);
    chk("post_rst_dropped", core_vs_cnt - vs0, 0, 0);
    drive_frame(3, 5, 1, -1, 1'b1);
    drive_idle(25);

    chk("pending_core", exp_cx_q.size(), 0, 0);
    chk("pending_pixels", exp_mag_q.size(), 0, 0);
    chk("pending_done", exp_done_q.size(), 0, 0);
    chk("sync_err_end", sync_err, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    chk("timeout", 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
